ttl_parity_sequencer: RTL

- Shares one XOR-reduction (parity) datapath among REQUESTERS channels.
- Each granted channel streams a frame of FRAME_LEN words; the block accumulates the frame's even parity and reports it with a one-cycle strobe.
- Round-robin arbitration between frames. Sits between bus-side sources and the parity/ECC checking logic of the CPU board model.

---
 rtl/ttl_parity_pkg.sv | 15 +
 rtl/ttl_rr_arbiter.sv | 32 +++
 rtl/ttl_parity_sequencer.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/ttl_parity_pkg.sv
// Shared state encoding and width helper for the parity sequencer.
package ttl_parity_pkg;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StAccum = 2'd1,
      StDone  = 2'd2
   } state_e;

   // Bits needed to hold 0..n-1, never less than one.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/ttl_rr_arbiter.sv
// Combinational round-robin pick: first set request searching upward from ptr_i+1.
module ttl_rr_arbiter
   import ttl_parity_pkg::*;
#(
   parameter int unsigned REQUESTERS = 4,
   localparam int unsigned IdxW = idx_width(REQUESTERS)
) (
   input  logic [REQUESTERS-1:0] req_i,
   input  logic [IdxW-1:0]       ptr_i,
   output logic [REQUESTERS-1:0] win_o,
   output logic [IdxW-1:0]       win_idx_o
);

   logic        found;
   int unsigned cand;

   always_comb begin
      win_o     = '0;
      win_idx_o = '0;
      found     = 1'b0;
      cand      = 0;
      for (int unsigned off = 1; off <= REQUESTERS; off++) begin
         cand = (32'(ptr_i) + off) % REQUESTERS;
         if (!found && req_i[IdxW'(cand)]) begin
            found                = 1'b1;
            win_o[IdxW'(cand)]   = 1'b1;
            win_idx_o            = IdxW'(cand);
         end
      end
   end

endmodule

// File: rtl/ttl_parity_sequencer.sv
// Round-robin shared parity accumulator over REQUESTERS framed channels.
// Optional Column output (frame-wide word XOR) when TTL_PARITY_COLUMN_EN is defined.
module ttl_parity_sequencer
   import ttl_parity_pkg::*;
#(
   parameter int unsigned REQUESTERS = 4,
   parameter int unsigned WIDTH      = 8,
   parameter int unsigned FRAME_LEN  = 4,
   parameter int unsigned DELAY_RISE = 0,
   parameter int unsigned DELAY_FALL = 0
) (
   input  logic                          Clk,
   input  logic                          Clear_bar,
   input  logic [REQUESTERS-1:0]         Req,
   input  logic [REQUESTERS*WIDTH-1:0]   Data_2D,
   input  logic [REQUESTERS-1:0]         Valid,
   output logic [REQUESTERS-1:0]         Ready,
   output logic [REQUESTERS-1:0]         Grant,
   output logic                          Parity,
   output logic [2:0]                    Parity_Chan,
   output logic                          Parity_Valid,
   output logic                          Abort,
`ifdef TTL_PARITY_COLUMN_EN
   output logic [WIDTH-1:0]              Column,
`endif
   output logic                          Busy
);

   localparam int unsigned IdxW = idx_width(REQUESTERS);
   localparam int unsigned CntW = idx_width(FRAME_LEN);
   localparam logic [CntW-1:0] LastCnt = CntW'(FRAME_LEN - 1);

   state_e                state_q;
   logic [REQUESTERS-1:0] grant_q;
   logic [IdxW-1:0]       ptr_q;
   logic [CntW-1:0]       cnt_q;
   logic                  acc_q, acc_d;
   logic                  parity_q, pvalid_q, abort_q;
   logic [2:0]            chan_q;

   logic [REQUESTERS-1:0] win;
   logic [IdxW-1:0]       win_idx;
   logic [WIDTH-1:0]      word;
   logic                  req_g, valid_g, start, accept, last;

   // Delays are simulation-only annotations; the synthesizable core ignores them.
   logic unused_delay;
   assign unused_delay = ^{DELAY_RISE, DELAY_FALL};

   ttl_rr_arbiter #(
      .REQUESTERS (REQUESTERS)
   ) u_arb (
      .req_i     (Req),
      .ptr_i     (ptr_q),
      .win_o     (win),
      .win_idx_o (win_idx)
   );

   always_comb begin
      word = '0;
      for (int unsigned i = 0; i < REQUESTERS; i++) begin
         if (grant_q[i]) word = Data_2D[i*WIDTH +: WIDTH];
      end
   end

   assign req_g   = |(Req & grant_q);
   assign valid_g = |(Valid & grant_q);
   assign start   = (state_q == StIdle) && (|Req);
   // Req low wins over Valid on the same edge.
   assign accept  = (state_q == StAccum) && req_g && valid_g;
   assign last    = accept && (cnt_q == LastCnt);
   assign acc_d   = acc_q ^ (^word);

   always_ff @(posedge Clk) begin
      if (!Clear_bar) begin
         state_q  <= StIdle;
         grant_q  <= '0;
         ptr_q    <= IdxW'(REQUESTERS - 1);
         cnt_q    <= '0;
         acc_q    <= 1'b0;
         parity_q <= 1'b0;
         chan_q   <= 3'd0;
         pvalid_q <= 1'b0;
         abort_q  <= 1'b0;
      end else begin
         pvalid_q <= 1'b0;
         abort_q  <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  grant_q <= win;
                  ptr_q   <= win_idx;
                  acc_q   <= 1'b0;
                  cnt_q   <= '0;
                  state_q <= StAccum;
               end
            end
            StAccum: begin
               if (!req_g) begin
                  abort_q <= 1'b1;
                  grant_q <= '0;
                  state_q <= StIdle;
               end else if (accept) begin
                  acc_q <= acc_d;
                  cnt_q <= cnt_q + 1'b1;
                  if (last) begin
                     parity_q <= acc_d;
                     chan_q   <= 3'(ptr_q);
                     pvalid_q <= 1'b1;
                     state_q  <= StDone;
                  end
               end
            end
            StDone: begin
               grant_q <= '0;
               state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

`ifdef TTL_PARITY_COLUMN_EN
   logic [WIDTH-1:0] col_acc_q, column_q;

   always_ff @(posedge Clk) begin
      if (!Clear_bar) begin
         col_acc_q <= '0;
         column_q  <= '0;
      end else begin
         if (start) begin
            col_acc_q <= '0;
         end else if (accept) begin
            col_acc_q <= col_acc_q ^ word;
         end
         if (last) column_q <= col_acc_q ^ word;
      end
   end

   assign Column = column_q;
`endif

   assign Ready        = grant_q & {REQUESTERS{state_q == StAccum}};
   assign Grant        = grant_q;
   assign Parity       = parity_q;
   assign Parity_Chan  = chan_q;
   assign Parity_Valid = pvalid_q;
   assign Abort        = abort_q;
   assign Busy         = (state_q == StAccum) || (state_q == StDone);

endmodule
